// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcode constants,
// per-format bit layouts and the field-packing/range-check function.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm4_0;
        logic [6:0] opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        logic [6:0] opcode;
    } b_type_t;

    typedef struct packed {
        logic [19:0] imm31_12;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } j_type_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_result_t;

    // Packs one instruction word; out-of-range immediates are still packed
    // (truncated) but flagged. Illegal formats give an all-zero flagged word.
    function automatic enc_result_t encode_fields(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_result_t        res;
        r_type_t            r;
        i_type_t            i;
        s_type_t            s;
        b_type_t            b;
        u_type_t            u;
        j_type_t            j;
        logic signed [31:0] simm;
        simm = $signed(imm);
        res  = '0;
        case (fmt)
            FMT_R: begin
                r = '{funct7: funct7, rs2: rs2, rs1: rs1, funct3: funct3, rd: rd, opcode: opcode};
                res.instr = r;
                res.err   = 1'b0;
            end
            FMT_I: begin
                i = '{imm11_0: imm[11:0], rs1: rs1, funct3: funct3, rd: rd, opcode: opcode};
                res.instr = i;
                res.err   = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_S: begin
                s = '{imm11_5: imm[11:5], rs2: rs2, rs1: rs1, funct3: funct3,
                      imm4_0: imm[4:0], opcode: opcode};
                res.instr = s;
                res.err   = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_B: begin
                b = '{imm12: imm[12], imm10_5: imm[10:5], rs2: rs2, rs1: rs1, funct3: funct3,
                      imm4_1: imm[4:1], imm11: imm[11], opcode: opcode};
                res.instr = b;
                res.err   = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            FMT_U: begin
                u = '{imm31_12: imm[31:12], rd: rd, opcode: opcode};
                res.instr = u;
                res.err   = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                j = '{imm20: imm[20], imm10_1: imm[10:1], imm11: imm[11],
                      imm19_12: imm[19:12], rd: rd, opcode: opcode};
                res.instr = j;
                res.err   = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: begin
                res.instr = 32'h0000_0000;
                res.err   = 1'b1;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head word and full/empty flags
// derived from an internal occupancy count. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage and pointers; reset clears the array so the head reads zero when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded RV32I fields into instruction words, tags each with a
// running byte address and buffers {instr, addr, err} for a memory writer.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_count
);

    localparam int FW = 32 + ADDR_W + 1;

    enc_result_t       enc;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] start_base;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;

    assign enc        = encode_fields(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                      in_funct3, in_funct7, in_imm);
    assign start_base = start_addr & ~(ADDR_W'(3));

    assign in_ready   = !fifo_full && !start_valid;
    assign push       = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    assign fifo_din   = {enc.instr, addr_q, enc.err};
    assign out_instr  = fifo_dout[FW-1 -: 32];
    assign out_addr   = fifo_dout[ADDR_W:1];
    assign out_err    = fifo_dout[0];

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address counter: a start request reloads the word-aligned base, otherwise advance per accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (start_valid) begin
            addr_q <= start_base;
        end else if (push) begin
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    // Saturating tally of accepted words that carried the error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (push && enc.err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal vectors followed by
// randomized traffic compared every cycle against a queue-based model.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_valid;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [15:0]       err_count;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_addr  (start_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } expWord_t;

    expWord_t    modelQ[$];
    logic [31:0] modelAddr     = '0;
    logic [15:0] modelErrCount = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference encoding from the field-placement rules using shifts and masks; returns {word, err}.
    function automatic logic [32:0] refEncode(input logic [31:0] fmt, input logic [31:0] op,
                                              input logic [31:0] rd, input logic [31:0] rs1,
                                              input logic [31:0] rs2, input logic [31:0] f3,
                                              input logic [31:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic        e;
        longint      v;
        v = $signed(imm);
        case (fmt)
            0: begin
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = 1'b0;
            end
            1: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = (v < -2048) || (v > 2047);
            end
            2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
                e = (v < -2048) || (v > 2047);
            end
            3: begin
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | op;
                e = (v < -4096) || (v > 4094) || ((imm & 32'h1) != 0);
            end
            4: begin
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
                e = ((imm & 32'hFFF) != 0);
            end
            5: begin
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (rd << 7) | op;
                e = (v < -1048576) || (v > 1048574) || ((imm & 32'h1) != 0);
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
        return {w, e};
    endfunction

    // Every falling edge: compare the DUT with the model, then advance the model to the next rising edge.
    initial begin
        logic     expReady;
        logic     doPush;
        logic     doPop;
        logic [32:0] enc;
        expWord_t ew;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                modelQ.delete();
                modelAddr     = '0;
                modelErrCount = '0;
                checkOutput("reset out_valid", out_valid, 0);
                checkOutput("reset in_ready", in_ready, 1);
                checkOutput("reset out_instr", out_instr, 0);
                checkOutput("reset out_addr", out_addr, 0);
                checkOutput("reset out_err", out_err, 0);
                checkOutput("reset err_count", err_count, 0);
            end else begin
                expReady = (modelQ.size() < DEPTH) && !start_valid;
                checkOutput("in_ready", in_ready, expReady);
                checkOutput("out_valid", out_valid, modelQ.size() > 0);
                if (modelQ.size() > 0) begin
                    checkOutput("out_instr", out_instr, modelQ[0].instr);
                    checkOutput("out_addr", out_addr, modelQ[0].addr);
                    checkOutput("out_err", out_err, modelQ[0].err);
                end
                checkOutput("err_count", err_count, modelErrCount);
                doPush = in_valid && expReady;
                doPop  = (modelQ.size() > 0) && out_ready;
                if (doPop) void'(modelQ.pop_front());
                if (doPush) begin
                    enc = refEncode(32'(in_fmt), 32'(in_opcode), 32'(in_rd), 32'(in_rs1),
                                    32'(in_rs2), 32'(in_funct3), 32'(in_funct7), in_imm);
                    ew.instr = enc[32:1];
                    ew.addr  = modelAddr;
                    ew.err   = enc[0];
                    modelQ.push_back(ew);
                    modelAddr = modelAddr + 32'd4;
                    if (enc[0] && modelErrCount != 16'hFFFF) modelErrCount = modelErrCount + 16'd1;
                end
                if (start_valid) modelAddr = start_addr & ~32'h3;
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
        bit done;
        done      = 1'b0;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept timeout: in_ready stayed 0, required 1 within 100 cycles");
        end
    endtask

    task automatic popCheck(input string name, input logic [31:0] instr, input logic [31:0] addr,
                            input logic err);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, " valid"}, out_valid, 1);
        checkOutput({name, " instr"}, out_instr, instr);
        checkOutput({name, " addr"}, out_addr, addr);
        checkOutput({name, " err"}, out_err, err);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic doStart(input logic [31:0] addr);
        start_valid = 1'b1;
        start_addr  = addr;
        @(negedge clk);
        checkOutput("in_ready during start", in_ready, 0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    function automatic logic [31:0] randImm();
        int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                        -4097, -4098, 1048574, 1048575, 1048576, -1048576, -1048578, 0};
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0:       r = $urandom();
            1:       r = bnd[$urandom_range(0, 15)];
            2:       r = $urandom() & 32'hFFFFF000;
            3:       r = $urandom_range(0, 8191) - 4096;
            default: r = $urandom_range(0, 4095) - 2048;
        endcase
        return r;
    endfunction

    // Directed scenarios followed by randomized traffic, then the summary.
    initial begin
        bit acc;
        reset       = 1'b1;
        start_valid = 1'b0;
        start_addr  = '0;
        in_valid    = 1'b0;
        in_fmt      = '0;
        in_opcode   = '0;
        in_rd       = '0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_funct3   = '0;
        in_funct7   = '0;
        in_imm      = '0;
        out_ready   = 1'b0;

        checkOutput("ref addi", refEncode(1, 'h13, 1, 0, 0, 0, 0, 5), {32'h00500093, 1'b0});
        checkOutput("ref sw", refEncode(2, 'h23, 0, 1, 2, 2, 0, 8), {32'h0020A423, 1'b0});
        checkOutput("ref add", refEncode(0, 'h33, 3, 1, 2, 0, 0, 0), {32'h002081B3, 1'b0});
        checkOutput("ref beq", refEncode(3, 'h63, 0, 0, 0, 0, 0, -8), {32'hFE000CE3, 1'b0});
        checkOutput("ref jal", refEncode(5, 'h6F, 0, 0, 0, 0, 0, -4), {32'hFFDFF06F, 1'b0});
        checkOutput("ref lui", refEncode(4, 'h37, 5, 0, 0, 0, 0, 'h12345000), {32'h123452B7, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("lit reset in_ready", in_ready, 1);
        checkOutput("lit reset out_valid", out_valid, 0);
        checkOutput("lit reset err_count", err_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        checkOutput("lit addi latency valid", out_valid, 1);
        checkOutput("lit addi latency instr", out_instr, 32'h00500093);
        @(posedge clk);
        #1;
        applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        popCheck("addi", 32'h00500093, 32'h0, 1'b0);
        popCheck("sw", 32'h0020A423, 32'h4, 1'b0);
        popCheck("add", 32'h002081B3, 32'h8, 1'b0);

        doStart(32'h100);
        applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8);
        applyStimulus(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        popCheck("beq", 32'hFE000CE3, 32'h100, 1'b0);
        popCheck("jal", 32'hFFDFF06F, 32'h104, 1'b0);

        applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        in_fmt    = 3'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("lit full in_ready", in_ready, 0);
        checkOutput("lit lui instr", out_instr, 32'h123452B7);
        checkOutput("lit lui addr", out_addr, 32'h108);
        checkOutput("lit lui err", out_err, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        checkOutput("lit err_count 4", err_count, 4);
        @(posedge clk);
        #1;
        popCheck("imm2048", 32'h80000093, 32'h10C, 1'b1);
        popCheck("b odd", 32'h00000163, 32'h110, 1'b1);
        popCheck("u low", 32'h123452B7, 32'h114, 1'b1);
        popCheck("fmt7", 32'h00000000, 32'h118, 1'b1);

        doStart(32'hFFFFFFFF);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        popCheck("wrap top", 32'h00500093, 32'hFFFFFFFC, 1'b0);
        popCheck("wrap zero", 32'hFFF00093, 32'h0, 1'b0);

        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        checkOutput("lit err_count 5", err_count, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("lit midreset out_valid", out_valid, 0);
        checkOutput("lit midreset in_ready", in_ready, 1);
        checkOutput("lit midreset err_count", err_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        popCheck("after reset", 32'h00500093, 32'h0, 1'b0);

        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_fmt    = 3'($urandom_range(0, 7));
                in_opcode = 7'($urandom());
                in_rd     = 5'($urandom());
                in_rs1    = 5'($urandom());
                in_rs2    = 5'($urandom());
                in_funct3 = 3'($urandom());
                in_funct7 = 7'($urandom());
                in_imm    = randImm();
            end
            start_valid = ($urandom_range(0, 40) == 0);
            start_addr  = $urandom();
            out_ready   = (c < 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        start_valid = 1'b0;
        out_ready   = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("drained out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
